// File: rtl/pair_batch_scheduler.sv
// Streams every unordered point pair as fixed-width batches: line r covers r..N-1,
// split into BATCH_SIZE-slot batches held stable until downstream accepts them.
module pair_batch_scheduler #(
  parameter int MAX_NODE_COUNT  = 2000,
  parameter int COORD_BIT_WIDTH = 12,
  parameter int DIMENSIONS      = 3,
  parameter int BATCH_SIZE      = 16,
  localparam int IDX_W = $clog2(MAX_NODE_COUNT),
  localparam int CNT_W = $clog2(MAX_NODE_COUNT + 1)
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   load_valid,
  input  logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]             load_coord,
  output logic                                                   load_ready,
  input  logic                                                   start,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   overflow,
  output logic [CNT_W-1:0]                                       node_count,
  input  logic                                                   out_ready,
  output logic [BATCH_SIZE-1:0][DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] batch_coords,
  output logic [BATCH_SIZE-1:0][IDX_W-1:0]                       batch_indices,
  output logic [BATCH_SIZE-1:0]                                  batch_valid,
  output logic                                                   batch_line_end,
  output logic                                                   batch_stream_end
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  // Wide enough that base + BATCH_SIZE never wraps, even when BATCH_SIZE > N.
  localparam int SUM_W_RAW = $clog2(MAX_NODE_COUNT + BATCH_SIZE) + 1;
  localparam int SUM_W     = (SUM_W_RAW > CNT_W + 1) ? SUM_W_RAW : CNT_W + 1;

  logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] point_mem [MAX_NODE_COUNT];

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] node_count_q, node_count_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] base_q, base_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic             stream;
  logic             full;
  logic             load_fire;
  logic [SUM_W-1:0] base_ext;
  logic [SUM_W-1:0] cnt_ext;
  logic [SUM_W-1:0] base_step;

  assign stream     = (state_q == S_STREAM);
  assign full       = (node_count_q == CNT_W'(MAX_NODE_COUNT));
  assign load_ready = !stream && !full;
  assign load_fire  = load_valid && load_ready;

  assign base_ext  = SUM_W'(base_q);
  assign cnt_ext   = SUM_W'(node_count_q);
  assign base_step = base_ext + SUM_W'(BATCH_SIZE);

  assign busy       = stream;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign node_count = node_count_q;

  for (genvar gi = 0; gi < BATCH_SIZE; gi++) begin : g_slot
    logic [SUM_W-1:0] slot_idx;
    logic             slot_valid;
    assign slot_idx           = base_ext + SUM_W'(gi);
    assign slot_valid         = stream && (slot_idx < cnt_ext);
    assign batch_valid[gi]    = slot_valid;
    assign batch_indices[gi]  = slot_idx[IDX_W-1:0];
    assign batch_coords[gi]   = slot_valid ? point_mem[slot_idx[IDX_W-1:0]] : '0;
  end

  assign batch_line_end   = stream && (base_step >= cnt_ext);
  assign batch_stream_end = batch_line_end && ((SUM_W'(ref_q) + SUM_W'(2)) == cnt_ext);

  always_comb begin
    state_d      = state_q;
    node_count_d = node_count_q;
    ref_d        = ref_q;
    base_d       = base_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (load_fire) begin
          node_count_d = node_count_q + CNT_W'(1);
        end else if (load_valid && full) begin
          overflow_d = 1'b1;
        end
        // A start that collides with an accepted load is dropped.
        if (start && !load_fire) begin
          if (node_count_q < CNT_W'(2)) begin
            done_d = 1'b1;
          end else begin
            state_d = S_STREAM;
            ref_d   = '0;
            base_d  = '0;
          end
        end
      end
      default: begin
        if (out_ready) begin
          if (!batch_line_end) begin
            base_d = base_step[CNT_W-1:0];
          end else if (!batch_stream_end) begin
            ref_d  = ref_q + CNT_W'(1);
            base_d = ref_q + CNT_W'(1);
          end else begin
            state_d      = S_IDLE;
            done_d       = 1'b1;
            node_count_d = '0;
            ref_d        = '0;
            base_d       = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      node_count_q <= '0;
      ref_q        <= '0;
      base_q       <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      node_count_q <= node_count_d;
      ref_q        <= ref_d;
      base_q       <= base_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      point_mem[node_count_q[IDX_W-1:0]] <= load_coord;
    end
  end

endmodule

// File: tb/tb_pair_batch_scheduler.sv
// Scoreboard bench: directed batch expectations are queued at stimulus time and
// popped by per-instance monitors whenever a batch transfers.
module tb_pair_batch_scheduler;

  typedef struct {
    int          base;
    logic [15:0] vmask;
    logic        le;
    logic        se;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: MAX_NODE_COUNT=4, BATCH_SIZE=16
  logic                    lv_a = 1'b0, st_a = 1'b0, ordy_a = 1'b0;
  logic [2:0][11:0]        lc_a = '0;
  logic                    lr_a, busy_a, done_a, ovf_a, le_a, se_a;
  logic [2:0]              nc_a;
  logic [15:0][2:0][11:0]  bc_a;
  logic [15:0][1:0]        bi_a;
  logic [15:0]             bv_a;

  // Instance B: MAX_NODE_COUNT=8, BATCH_SIZE=2
  logic                    lv_b = 1'b0, st_b = 1'b0, ordy_b = 1'b0;
  logic [2:0][11:0]        lc_b = '0;
  logic                    lr_b, busy_b, done_b, ovf_b, le_b, se_b;
  logic [3:0]              nc_b;
  logic [1:0][2:0][11:0]   bc_b;
  logic [1:0][2:0]         bi_b;
  logic [1:0]              bv_b;

  pair_batch_scheduler #(.MAX_NODE_COUNT(4), .COORD_BIT_WIDTH(12), .DIMENSIONS(3), .BATCH_SIZE(16)) dut_a (
    .clk(clk), .rst(rst), .load_valid(lv_a), .load_coord(lc_a), .load_ready(lr_a),
    .start(st_a), .busy(busy_a), .done(done_a), .overflow(ovf_a), .node_count(nc_a),
    .out_ready(ordy_a), .batch_coords(bc_a), .batch_indices(bi_a), .batch_valid(bv_a),
    .batch_line_end(le_a), .batch_stream_end(se_a));

  pair_batch_scheduler #(.MAX_NODE_COUNT(8), .COORD_BIT_WIDTH(12), .DIMENSIONS(3), .BATCH_SIZE(2)) dut_b (
    .clk(clk), .rst(rst), .load_valid(lv_b), .load_coord(lc_b), .load_ready(lr_b),
    .start(st_b), .busy(busy_b), .done(done_b), .overflow(ovf_b), .node_count(nc_b),
    .out_ready(ordy_b), .batch_coords(bc_b), .batch_indices(bi_b), .batch_valid(bv_b),
    .batch_line_end(le_b), .batch_stream_end(se_b));

  int checks = 0;
  int errors = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [35:0] pts_a[8];
  logic [35:0] pts_b[8];
  int          m_a = 0;
  int          m_b = 0;

  function automatic void cmp(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [35:0] pt(int i);
    return {12'(i * 7 + 300), 12'(i * 5 + 200), 12'(i * 3 + 100)};
  endfunction

  function automatic void push(bit sb, int b, logic [15:0] m, logic le, logic se);
    exp_t e;
    e.base = b; e.vmask = m; e.le = le; e.se = se;
    if (sb) q_b.push_back(e); else q_a.push_back(e);
  endfunction

  // Monitor A
  exp_t        ea;
  logic        hold_a = 1'b0;
  logic [49:0] snap_meta_a;
  logic [575:0] snap_c_a;
  always @(negedge clk) begin
    if (rst) begin
      hold_a = 1'b0;
    end else if (!busy_a) begin
      hold_a = 1'b0;
      cmp("idle_quiet_a", {bv_a, le_a, se_a}, 64'h0);
    end else begin
      if (hold_a) cmp("hold_a", ({bv_a, bi_a, le_a, se_a} == snap_meta_a) && (bc_a == snap_c_a), 64'h1);
      if (ordy_a) begin
        hold_a = 1'b0;
        if (q_a.size() == 0) begin
          cmp("unexpected_batch_a", 64'h1, 64'h0);
        end else begin
          ea = q_a.pop_front();
          $display("A batch base=%0d valid=%b line_end=%b stream_end=%b", ea.base, bv_a, le_a, se_a);
          cmp("valid_a", bv_a, ea.vmask);
          cmp("line_end_a", le_a, ea.le);
          cmp("stream_end_a", se_a, ea.se);
          for (int k = 0; k < 16; k++) begin
            if (ea.vmask[k]) begin
              cmp("index_a", bi_a[k], ea.base + k);
              cmp("coord_a", bc_a[k], pts_a[ea.base + k]);
            end
          end
        end
      end else begin
        hold_a = 1'b1;
        snap_meta_a = {bv_a, bi_a, le_a, se_a};
        snap_c_a = bc_a;
      end
    end
  end

  // Monitor B
  exp_t        eb;
  logic        hold_b = 1'b0;
  logic [9:0]  snap_meta_b;
  logic [71:0] snap_c_b;
  always @(negedge clk) begin
    if (rst) begin
      hold_b = 1'b0;
    end else if (!busy_b) begin
      hold_b = 1'b0;
      cmp("idle_quiet_b", {bv_b, le_b, se_b}, 64'h0);
    end else begin
      if (hold_b) cmp("hold_b", ({bv_b, bi_b, le_b, se_b} == snap_meta_b) && (bc_b == snap_c_b), 64'h1);
      if (ordy_b) begin
        hold_b = 1'b0;
        if (q_b.size() == 0) begin
          cmp("unexpected_batch_b", 64'h1, 64'h0);
        end else begin
          eb = q_b.pop_front();
          $display("B batch base=%0d valid=%b line_end=%b stream_end=%b", eb.base, bv_b, le_b, se_b);
          cmp("valid_b", bv_b, eb.vmask[1:0]);
          cmp("line_end_b", le_b, eb.le);
          cmp("stream_end_b", se_b, eb.se);
          for (int k = 0; k < 2; k++) begin
            if (eb.vmask[k]) begin
              cmp("index_b", bi_b[k], eb.base + k);
              cmp("coord_b", bc_b[k], pts_b[eb.base + k]);
            end
          end
        end
      end else begin
        hold_b = 1'b1;
        snap_meta_b = {bv_b, bi_b, le_b, se_b};
        snap_c_b = bc_b;
      end
    end
  end

  task automatic load_pt(input bit sb, input logic [35:0] c);
    if (sb) begin lv_b = 1'b1; lc_b = c; end
    else    begin lv_a = 1'b1; lc_a = c; end
    @(posedge clk); #1;
    lv_a = 1'b0; lv_b = 1'b0;
    if (sb) begin
      if (m_b < 8) begin pts_b[m_b] = c; m_b++; end
    end else begin
      if (m_a < 4) begin pts_a[m_a] = c; m_a++; end
    end
  endtask

  task automatic pulse_start(input bit sb);
    if (sb) st_b = 1'b1; else st_a = 1'b1;
    @(posedge clk); #1;
    st_a = 1'b0; st_b = 1'b0;
  endtask

  // mode 1: out_ready high one cycle in three
  task automatic wait_done(input bit sb, input int mode, input int exp_lat, input int exp_nc);
    int lat = 0;
    int c = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (sb ? done_b : done_a) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
        if (mode == 1) begin
          if (sb) ordy_b = (c % 3 == 2); else ordy_a = (c % 3 == 2);
        end
      end
    end
    cmp("done_seen", seen, 1);
    if (seen) begin
      if (exp_lat > 0) cmp("done_latency", lat, exp_lat);
      cmp("busy_at_done", sb ? busy_b : busy_a, 0);
      cmp("count_at_done", sb ? nc_b : nc_a, exp_nc);
      cmp("queue_drained", sb ? q_b.size() : q_a.size(), 0);
      @(negedge clk);
      cmp("done_one_cycle", sb ? done_b : done_a, 0);
    end
    if (exp_nc == 0) begin
      if (sb) m_b = 0; else m_a = 0;
    end
    ordy_a = 1'b0; ordy_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_busy_a", busy_a, 0);      cmp("rst_done_a", done_a, 0);
    cmp("rst_ovf_a", ovf_a, 0);        cmp("rst_count_a", nc_a, 0);
    cmp("rst_ready_a", lr_a, 1);       cmp("rst_busy_b", busy_b, 0);
    cmp("rst_count_b", nc_b, 0);       cmp("rst_valid_b", bv_b, 0);
    @(negedge clk); rst = 1'b0;

    // Start with 0 points, then with 1 point: done only, no batch
    pulse_start(0);
    wait_done(0, 0, 1, 0);
    load_pt(0, pt(0));
    pulse_start(0);
    wait_done(0, 0, 1, 1);

    rst = 1'b1; @(posedge clk); #1;
    cmp("rst_clears_count_a", nc_a, 0);
    rst = 1'b0; m_a = 0;

    // 3 points, full-rate downstream
    for (int i = 0; i < 3; i++) load_pt(0, pt(i));
    push(0, 0, 16'b111, 1, 0);
    push(0, 1, 16'b011, 1, 1);
    ordy_a = 1'b1;
    pulse_start(0);
    wait_done(0, 0, 0, 0);

    // start alongside an accepted load is ignored; then throttled downstream
    load_pt(0, pt(3));
    load_pt(0, pt(4));
    st_a = 1'b1;
    load_pt(0, pt(5));
    st_a = 1'b0;
    @(negedge clk);
    cmp("start_with_load_ignored", busy_a, 0);
    cmp("count_after_load3", nc_a, 3);
    push(0, 0, 16'b111, 1, 0);
    push(0, 1, 16'b011, 1, 1);
    ordy_a = 1'b0;
    pulse_start(0);
    wait_done(0, 1, 0, 0);

    // Fill to capacity, overflow on the fifth write, start while busy ignored
    for (int i = 0; i < 4; i++) load_pt(0, pt(20 + i));
    lv_a = 1'b1; lc_a = pt(24);
    @(negedge clk);
    cmp("ready_low_full", lr_a, 0);
    @(posedge clk); #1; lv_a = 1'b0;
    @(negedge clk);
    cmp("overflow_set", ovf_a, 1);
    cmp("count_full", nc_a, 4);
    push(0, 0, 16'b1111, 1, 0);
    push(0, 1, 16'b0111, 1, 0);
    push(0, 2, 16'b0011, 1, 1);
    ordy_a = 1'b0;
    pulse_start(0);
    @(negedge clk);
    cmp("busy_after_start", busy_a, 1);
    pulse_start(0);
    ordy_a = 1'b1;
    wait_done(0, 0, 0, 0);
    cmp("overflow_sticky", ovf_a, 1);

    // BATCH_SIZE=2, 5 points: 8 batches
    for (int i = 0; i < 5; i++) load_pt(1, pt(10 + i));
    push(1, 0, 16'b11, 0, 0); push(1, 2, 16'b11, 0, 0); push(1, 4, 16'b01, 1, 0);
    push(1, 1, 16'b11, 0, 0); push(1, 3, 16'b11, 1, 0);
    push(1, 2, 16'b11, 0, 0); push(1, 4, 16'b01, 1, 0);
    push(1, 3, 16'b11, 1, 1);
    ordy_b = 1'b1;
    pulse_start(1);
    wait_done(1, 0, 0, 0);

    // Asynchronous reset three batches into the same stream
    for (int i = 0; i < 5; i++) load_pt(1, pt(30 + i));
    push(1, 0, 16'b11, 0, 0); push(1, 2, 16'b11, 0, 0); push(1, 4, 16'b01, 1, 0);
    ordy_b = 1'b1;
    pulse_start(1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    cmp("midrst_busy", busy_b, 0);     cmp("midrst_valid", bv_b, 0);
    cmp("midrst_line_end", le_b, 0);   cmp("midrst_stream_end", se_b, 0);
    cmp("midrst_count", nc_b, 0);      cmp("midrst_done", done_b, 0);
    cmp("midrst_queue", q_b.size(), 0);
    q_a.delete(); q_b.delete(); m_a = 0; m_b = 0;
    ordy_b = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("no_done_after_rst", {done_b, busy_b}, 0);
    end
    load_pt(1, pt(40));
    load_pt(1, pt(41));
    push(1, 0, 16'b11, 1, 1);
    ordy_b = 1'b1;
    pulse_start(1);
    wait_done(1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_batch_scheduler.md
PAIR_BATCH_SCHEDULER -- requirements
Module: pair_batch_scheduler

Interface
REQ-001 SHALL have parameter MAX_NODE_COUNT, default 2000, maximum storable points.
REQ-002 SHALL have parameter COORD_BIT_WIDTH, default 12, width of one coordinate.
REQ-003 SHALL have parameter DIMENSIONS, default 3, coordinates per point.
REQ-004 SHALL have parameter BATCH_SIZE, default 16, slots per output batch.
REQ-005 SHALL derive IDX_W = $clog2(MAX_NODE_COUNT) and CNT_W = $clog2(MAX_NODE_COUNT+1).
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port load_valid, input, 1, point write request.
REQ-009 SHALL have port load_coord, input, [DIMENSIONS][COORD_BIT_WIDTH], point to store.
REQ-010 SHALL have port load_ready, output, 1, point write accepted this cycle when high with load_valid.
REQ-011 SHALL have port start, input, 1, begin sweep over loaded points.
REQ-012 SHALL have port busy, output, 1, sweep in progress.
REQ-013 SHALL have port done, output, 1, one-cycle sweep-complete pulse.
REQ-014 SHALL have port overflow, output, 1, sticky flag: write attempted while full.
REQ-015 SHALL have port node_count, output, CNT_W, points currently loaded.
REQ-016 SHALL have port out_ready, input, 1, downstream accepts batch.
REQ-017 SHALL have ports batch_coords [BATCH_SIZE][DIMENSIONS][COORD_BIT_WIDTH] and batch_indices [BATCH_SIZE][IDX_W], outputs, slot payloads.
REQ-018 SHALL have ports batch_valid [BATCH_SIZE], batch_line_end 1, batch_stream_end 1, outputs, slot valids and framing.

Function
REQ-019 SHALL implement states IDLE and STREAM; busy = (state == STREAM).
REQ-020 SHALL assert load_ready = IDLE && node_count < MAX_NODE_COUNT; accepted load writes point at address node_count, node_count increments next cycle.
REQ-021 SHALL, on load_valid && IDLE && node_count == MAX_NODE_COUNT, set overflow and drop the point.
REQ-022 SHALL ignore start when a load is accepted in the same cycle, and ignore start in STREAM.
REQ-023 SHALL, on start in IDLE with node_count < 2, emit no batch and pulse done the next cycle, staying IDLE.
REQ-024 SHALL, on start in IDLE with node_count >= 2, enter STREAM next cycle with ref = 0, base = 0.
REQ-025 SHALL, in STREAM, for line ref r (0..N-2), emit batches covering indices r..N-1 in ascending order, base stepping by BATCH_SIZE from r; slot k carries index base+k, coords of that point, valid iff base+k < N.
REQ-026 SHALL make slot 0 of a line's first batch index r itself (reference point).
REQ-027 SHALL assert batch_line_end on a line's final batch (base+BATCH_SIZE >= N) and batch_stream_end only on the line_end batch of r = N-2.
REQ-028 SHALL hold all batch outputs stable until transfer; transfer = busy && out_ready; batch_valid is all-zero outside STREAM.
REQ-029 SHALL, on transfer of a non-final batch, advance base; of a line_end non-stream_end batch, set r+1 and base = r+1.
REQ-030 SHALL, on transfer of the stream_end batch, return to IDLE, pulse done one cycle later (busy low same cycle as done), and clear node_count to 0.
REQ-031 SHALL compute base+k, N-r comparisons at CNT_W+1 bits without wrap.
REQ-032 SHALL read point storage combinationally from registered r/base; payload of invalid slots is don't-care.

Reset
REQ-033 SHALL, on rst asserted at any time including mid-STREAM, asynchronously force IDLE, busy 0, done 0, overflow 0, node_count 0, batch_valid 0, line_end 0, stream_end 0, ref/base 0; point storage contents unspecified.
REQ-034 SHALL accept loads the first clk edge after rst deassertion.

Verification
REQ-035 Load 3 points, BATCH_SIZE=16, start, out_ready=1 -> 2 batches: indices {0,1,2} valid 0b111 line_end; {1,2} valid 0b11 line_end+stream_end; done next cycle; node_count 0.
REQ-036 BATCH_SIZE=2, 5 points -> 8 batches: (0,1)(2,3)(4)|(1,2)(3,4)|(2,3)(4)|(3,4) line_end on batches 3,5,7,8; stream_end only on 8.
REQ-037 Same as REQ-035 with out_ready toggling 1 of 3 cycles -> identical batch sequence, outputs unchanged while out_ready low.
REQ-038 Load 1 point, start -> no batch_valid ever, done pulse next cycle; start with 0 points same.
REQ-039 MAX_NODE_COUNT=4, 5 loads -> load_ready low on 5th, overflow 1, node_count 4; start while busy ignored.
REQ-040 rst pulse mid-STREAM of REQ-036 -> outputs zero immediately, no done; reload 2 points, start -> single batch (0,1) line_end+stream_end.
